ma_decimator_fifo: RTL and testbench
====================================

// Module: ma_decimator_fifo
// PURPOSE
//  Downstream stage of the 8-tap moving-average filter.
//  - Consumes the filter's signed 16-bit output stream, one sample per enabled clock.
//  - Keeps every DECIM-th sample; the 8-tap MA acts as the anti-alias filter.
//  - Buffers kept samples in a first-word-fall-through FIFO.
//  - Presents them to the consumer over a valid/ready handshake.
//  - Flags samples lost to back-pressure.
// PARAMETERS
//  DATA_W  16  sample width, two's complement, passed through bit-exact
//  DECIM   8   decimation ratio, >=1; DECIM=1 keeps every sample
//  DEPTH   16  FIFO depth in samples, power of two, >=2
// PORTS
//  clk           in   1                        rising-edge clock
//  reset_n       in   1                        async active-low reset
//  d             in   DATA_W                   signed sample from filter q
//  in_en         in   1                        d is a new sample this cycle (tie 1 for free-run)
//  q_data        out  DATA_W                   signed FIFO head sample
//  q_valid       out  1                        q_data holds an unread sample
//  q_ready       in   1                        consumer accepts q_data this cycle
//  fill_level    out  $clog2(DEPTH)+1          samples currently stored
//  overflow      out  1                        sticky: a kept sample was dropped
//  clr_overflow  in   1                        sync clear of overflow
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - phase=0; FIFO empty; q_data=0; q_valid=0; fill_level=0; overflow=0.
//  Decimation phase counter
//   - Range 0..DECIM-1. Advances only when in_en=1; wraps DECIM-1 -> 0.
//   - Holds its value while in_en=0.
//   - A sample is kept when in_en=1 and phase==0.
//   - The first enabled sample after reset is therefore kept.
//  Push and pop
//   - push = keep & (~full | pop).
//   - pop  = q_valid & q_ready.
//   - A kept sample with full & ~pop is dropped: overflow<=1 and FIFO unchanged.
//  Simultaneous push and pop
//   - Allowed at any fill level, including full: fill_level is unchanged.
//   - The full+pop+push case is not an overflow.
//  Overflow flag
//   - clr_overflow has priority over a same-cycle drop: overflow ends at 0.
//  Latency and output timing
//   - A kept sample captured at edge N into an empty FIFO gives q_valid=1 and q_data=sample after edge N.
//   - Sustained throughput is 1 sample per clock when DECIM=1 and q_ready=1.
//   - q_data is registered head-of-queue; it changes only after a pop or an empty->non-empty push.
//   - q_data is held stable while q_valid=1 and q_ready=0.
//   - When empty, q_data holds its last value and is don't-care.
//  State and arithmetic
//   - Storage: circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH.
//   - full/empty are derived from fill_level; no extra state.
//   - No arithmetic on sample data: -32768 and +32767 pass unchanged.
//   - q_ready while q_valid=0 is ignored.
//  Reset mid-operation
//   - Flushes the FIFO, discards any in-flight sample and zeroes phase.
//   - Next enabled sample after release is kept.
// TESTING (DECIM=8, DEPTH=16 unless noted)
//  T1 reset: hold reset_n=0 for 40ns with d toggling
//     -> q_valid=0, fill_level=0, overflow=0, q_data=0.
//  T2 ramp free-run: in_en=1, q_ready=1, d=0,1,2,...
//     -> q_valid pulses one cycle in every 8; q_data=0,8,16,...; fill_level never exceeds 1.
//  T3 back-pressure: q_ready=0, ramp of 136 samples
//     -> fill_level=16; overflow=1 after sample 128 dropped;
//     -> then q_ready=1 reads 0,8,...,120 in order.
//  T4 in_en gaps: alternate in_en 1/0 on a ramp
//     -> kept samples are still d=0,8,16 (counted by enabled samples, not clocks).
//  T5 full+pop+push: fill to 16, then assert q_ready on the cycle a sample is kept
//     -> push accepted; fill_level stays 16; overflow stays 0.
//  T6 extremes and reset: d=16'sh7FFF, then 16'sh8000 (DECIM=1)
//     -> passed bit-exact;
//     -> mid-stream reset flushes, then the first post-reset sample appears at q_data.

Source files
------------

// File: rtl/ma_decimator_fifo.sv
// ma_decimator_fifo: keeps every DECIM-th enabled sample from the moving-average
// filter and buffers it in a first-word-fall-through FIFO. The FIFO head is held
// in a register. Samples are offered to the consumer over a valid/ready handshake.
// A sticky flag records any kept sample that was dropped because the FIFO was full.
module ma_decimator_fifo #(
  parameter int DATA_W = 16,
  parameter int DECIM  = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_W-1:0]        d,
  input  logic                     in_en,
  output logic [DATA_W-1:0]        q_data,
  output logic                     q_valid,
  input  logic                     q_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [PH_W-1:0]   phase_q, phase_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic [DATA_W-1:0] q_data_q, q_data_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              keep, full, empty, push, pop, drop;
  logic [PTR_W-1:0]  rd_next;

  assign q_data     = q_data_q;
  assign q_valid    = ~empty;
  assign fill_level = fill_q;
  assign overflow   = overflow_q;

  // Next-state logic: phase counting, push/pop decisions, head register and overflow flag
  always_comb begin
    phase_d    = phase_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    q_data_d   = q_data_q;
    overflow_d = overflow_q;

    full    = (fill_q == CNT_W'(DEPTH));
    empty   = (fill_q == '0);
    keep    = in_en && (phase_q == '0);
    pop     = ~empty && q_ready;
    push    = keep && (~full || pop);
    drop    = keep && full && ~pop;
    rd_next = rd_ptr_q + PTR_W'(1);

    if (in_en) begin
      if (phase_q == PH_W'(DECIM - 1)) phase_d = '0;
      else                             phase_d = phase_q + PH_W'(1);
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_next;

    fill_d = fill_q + CNT_W'(push) - CNT_W'(pop);

    // With one entry left, popping and pushing together makes the incoming sample the new head,
    // since it has not reached the memory yet.
    if (pop) begin
      if (fill_q == CNT_W'(1)) begin
        if (push) q_data_d = d;
      end else begin
        q_data_d = mem_q[rd_next];
      end
    end else if (push && empty) begin
      q_data_d = d;
    end

    if (clr_overflow) overflow_d = 1'b0;
    else if (drop)    overflow_d = 1'b1;
  end

  // Control and head-of-queue registers, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      q_data_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      q_data_q   <= q_data_d;
      overflow_q <= overflow_d;
    end
  end

  // Sample storage; it has no reset because the pointers and fill count decide what is valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= d;
  end

endmodule

// File: tb/tb_ma_decimator_fifo.sv
// tb_ma_decimator_fifo: directed bench for ma_decimator_fifo.
// One instance uses DECIM=8 and the other uses DECIM=1; both have DEPTH=16.
module tb_ma_decimator_fifo;

  logic        clk = 1'b0;
  logic        reset_n;

  logic [15:0] d8, q_data8;
  logic        in_en8, q_ready8, clr8, q_valid8, ovf8;
  logic [4:0]  fill8;

  logic [15:0] d1, q_data1;
  logic        in_en1, q_ready1, clr1, q_valid1, ovf1;
  logic [4:0]  fill1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rst_before;
    logic        in_en;
    logic [15:0] d;
    logic        q_ready;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic [4:0]  exp_fill;
  } vec_t;

  vec_t vecs[$];

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  ma_decimator_fifo #(.DATA_W(16), .DECIM(8), .DEPTH(16)) dut8 (
    .clk(clk), .reset_n(reset_n), .d(d8), .in_en(in_en8),
    .q_data(q_data8), .q_valid(q_valid8), .q_ready(q_ready8),
    .fill_level(fill8), .overflow(ovf8), .clr_overflow(clr8)
  );

  ma_decimator_fifo #(.DATA_W(16), .DECIM(1), .DEPTH(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .d(d1), .in_en(in_en1),
    .q_data(q_data1), .q_valid(q_valid1), .q_ready(q_ready1),
    .fill_level(fill1), .overflow(ovf1), .clr_overflow(clr1)
  );

  // Safety net so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic en, input logic [15:0] dv, input logic rdy, input logic clr);
    in_en8   = en;
    d8       = dv;
    q_ready8 = rdy;
    clr8     = clr;
    tick();
  endtask

  task automatic doReset();
    in_en8 = 0; d8 = 0; q_ready8 = 0; clr8 = 0;
    in_en1 = 0; d1 = 0; q_ready1 = 0; clr1 = 0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Test sequence
  initial begin
    in_en8 = 0; d8 = 0; q_ready8 = 0; clr8 = 0;
    in_en1 = 0; d1 = 0; q_ready1 = 0; clr1 = 0;
    reset_n = 1'b0;
    @(negedge clk);

    // T1: reset held for 40 ns with d toggling
    for (int i = 0; i < 4; i++) begin
      d8 = d8 ^ 16'hFFFF;
      d1 = d1 ^ 16'hA5A5;
      in_en8 = 1; in_en1 = 1; q_ready8 = 1;
      tick();
    end
    checkOutput("t1_valid8", q_valid8, 0);
    checkOutput("t1_fill8",  fill8, 0);
    checkOutput("t1_ovf8",   ovf8, 0);
    checkOutput("t1_data8",  q_data8, 0);
    checkOutput("t1_valid1", q_valid1, 0);
    checkOutput("t1_data1",  q_data1, 0);
    reset_n = 1'b1;
    in_en8 = 0; in_en1 = 0;

    // Build the table: T2 ramp free-run, then T4 in_en gaps
    for (int i = 0; i < 17; i++) begin
      vec_t v;
      v.rst_before = (i == 0);
      v.in_en      = 1;
      v.d          = 16'(i);
      v.q_ready    = 1;
      v.exp_valid  = (i % 8 == 0);
      v.exp_data   = 16'(8 * (i / 8));
      v.exp_fill   = (i % 8 == 0) ? 5'd1 : 5'd0;
      vecs.push_back(v);
    end
    for (int k = 0; k < 34; k++) begin
      vec_t v;
      int j;
      j = k / 2;
      v.rst_before = (k == 0);
      v.in_en      = (k % 2 == 0);
      v.d          = (k % 2 == 0) ? 16'(j) : 16'h5555;
      v.q_ready    = 1;
      v.exp_valid  = (k % 2 == 0) && (j % 8 == 0);
      v.exp_data   = 16'(j);
      v.exp_fill   = v.exp_valid ? 5'd1 : 5'd0;
      vecs.push_back(v);
    end

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) doReset();
      applyStimulus(vecs[i].in_en, vecs[i].d, vecs[i].q_ready, 1'b0);
      checkOutput($sformatf("vec%0d_valid", i), q_valid8, vecs[i].exp_valid);
      checkOutput($sformatf("vec%0d_fill", i), fill8, vecs[i].exp_fill);
      if (vecs[i].exp_valid)
        checkOutput($sformatf("vec%0d_data", i), q_data8, vecs[i].exp_data);
    end

    // T3: back-pressure over 136 samples, then an in-order drain
    doReset();
    for (int i = 0; i < 136; i++) begin
      applyStimulus(1, 16'(i), 0, 0);
      if (i == 127) begin
        checkOutput("t3_fill_127", fill8, 16);
        checkOutput("t3_ovf_127",  ovf8, 0);
      end
      if (i == 128) begin
        checkOutput("t3_ovf_128",  ovf8, 1);
        checkOutput("t3_fill_128", fill8, 16);
      end
    end
    checkOutput("t3_fill_end", fill8, 16);
    checkOutput("t3_head_hold", q_data8, 0);
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("t3_rd%0d_valid", k), q_valid8, 1);
      checkOutput($sformatf("t3_rd%0d_data", k), q_data8, 32'(8 * k));
      applyStimulus(0, 0, 1, 0);
    end
    checkOutput("t3_empty_valid", q_valid8, 0);
    checkOutput("t3_empty_fill",  fill8, 0);
    checkOutput("t3_ovf_sticky",  ovf8, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t3_ovf_clr", ovf8, 0);

    // T5: full FIFO with pop and push in the same cycle, then clear-versus-drop priority
    doReset();
    for (int i = 0; i < 128; i++) applyStimulus(1, 16'(i), 0, 0);
    checkOutput("t5_fill_pre", fill8, 16);
    applyStimulus(1, 16'd128, 1, 0);
    checkOutput("t5_fill_pp",  fill8, 16);
    checkOutput("t5_ovf_pp",   ovf8, 0);
    checkOutput("t5_valid_pp", q_valid8, 1);
    checkOutput("t5_head_pp",  q_data8, 8);
    for (int i = 129; i < 136; i++) applyStimulus(1, 16'(i), 0, 0);
    applyStimulus(1, 16'd136, 0, 1);
    checkOutput("t5_clr_prio_ovf",  ovf8, 0);
    checkOutput("t5_clr_prio_fill", fill8, 16);
    for (int i = 137; i < 144; i++) applyStimulus(1, 16'(i), 0, 0);
    applyStimulus(1, 16'd144, 0, 0);
    checkOutput("t5_drop_ovf", ovf8, 1);
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("t5_rd%0d_data", k), q_data8, 32'(8 * (k + 1)));
      applyStimulus(0, 0, 1, 0);
    end
    checkOutput("t5_empty_fill", fill8, 0);

    // T6: extreme values through DECIM=1, then a mid-stream reset on both instances
    doReset();
    in_en1 = 1; q_ready1 = 1; d1 = 16'h7FFF;
    in_en8 = 1; q_ready8 = 1; d8 = 16'd0;
    tick();
    checkOutput("t6_valid_max", q_valid1, 1);
    checkOutput("t6_data_max",  q_data1, 16'h7FFF);
    checkOutput("t6_fill_max",  fill1, 1);
    d1 = 16'h8000; d8 = 16'd1;
    tick();
    checkOutput("t6_data_min",  q_data1, 16'h8000);
    checkOutput("t6_fill_min",  fill1, 1);
    q_ready1 = 0; d1 = 16'd1; d8 = 16'd2;
    tick();
    d1 = 16'd2; d8 = 16'd3;
    tick();
    checkOutput("t6_fill_bp",  fill1, 3);
    checkOutput("t6_head_bp",  q_data1, 16'h8000);
    reset_n = 1'b0;
    d1 = 16'd5; d8 = 16'd4;
    tick();
    checkOutput("t6_rst_fill1",  fill1, 0);
    checkOutput("t6_rst_valid1", q_valid1, 0);
    checkOutput("t6_rst_data1",  q_data1, 0);
    checkOutput("t6_rst_fill8",  fill8, 0);
    reset_n = 1'b1;
    d1 = 16'h1234; d8 = 16'h00AB; q_ready1 = 1; q_ready8 = 0;
    tick();
    checkOutput("t6_post_valid1", q_valid1, 1);
    checkOutput("t6_post_data1",  q_data1, 16'h1234);
    checkOutput("t6_post_fill1",  fill1, 1);
    checkOutput("t6_post_valid8", q_valid8, 1);
    checkOutput("t6_post_data8",  q_data8, 16'h00AB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
